// File: rtl/updown_mod_counter.sv
// updown_mod_counter: parametrised up/down modulo counter with
// wrap/saturate mode, clamped load, TC flag and registered WRAP pulse.
// Optional compare output is enabled by defining COUNTER_CMP_EN.

module updown_mod_counter #(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MODULUS  = 256,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic             LOAD,
    input  logic             UP,
    input  logic [WIDTH-1:0] DATA,
`ifdef COUNTER_CMP_EN
    input  logic [WIDTH-1:0] CMP_VAL,
    output logic             CMP_MATCH,
`endif
    output logic [WIDTH-1:0] COUNT,
    output logic             TC,
    output logic             WRAP
);

    localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (count_q == MAX);
    assign at_zero = (count_q == ZERO);

    // Next count: load (clamped to MAX) beats enable; ends wrap or saturate.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (LOAD) begin
            count_d = (DATA > MAX) ? MAX : DATA;
        end else if (ENABLE) begin
            if (UP) begin
                if (at_max) begin
                    count_d = SATURATE ? MAX : ZERO;
                    wrap_d  = !SATURATE;
                end else begin
                    count_d = count_q + ONE;
                end
            end else begin
                if (at_zero) begin
                    count_d = SATURATE ? ZERO : MAX;
                    wrap_d  = !SATURATE;
                end else begin
                    count_d = count_q - ONE;
                end
            end
        end
    end

    // Count and wrap-pulse registers, cleared asynchronously.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            count_q <= ZERO;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign COUNT = count_q;
    assign WRAP  = wrap_q;
    assign TC    = UP ? at_max : at_zero;

`ifdef COUNTER_CMP_EN
    logic cmp_match_q;
    logic cmp_match_d;

    // Compare against the next count so the flag aligns with COUNT.
    always_comb begin
        cmp_match_d = (count_d == CMP_VAL);
    end

    // Compare flag register.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            cmp_match_q <= 1'b0;
        end else begin
            cmp_match_q <= cmp_match_d;
        end
    end

    assign CMP_MATCH = cmp_match_q;
`endif

endmodule
